seq_add_sub: RTL

//  Parametrised, multi-cycle adder/subtractor. Operands are accepted over a valid/ready

---
 rtl/seq_add_sub.sv | 100 ++++++++++
 1 files changed

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock, LS chunk first.
// Operand and result handshakes are valid/ready.
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             over_flow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] res;
  logic             c_nxt;
  logic             msb_cin;
  logic             last;

  // Operands shift right so the active chunk always sits at bit 0.
  assign a_ch = a_q[CHUNK-1:0];
  assign b_ch = b_q[CHUNK-1:0];

  assign {c_nxt, res} = {1'b0, a_ch} + {1'b0, b_ch}
                      + {{CHUNK{1'b0}}, carry};

  // Carry into the chunk's top bit recovered from its sum bit.
  assign msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ res[CHUNK-1];
  assign last    = (idx == IW'(NCHUNK - 1));

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      over_flow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          carry <= c_nxt;
          sum   <= (sum >> CHUNK)
                 | (WIDTH'(res) << (WIDTH - CHUNK));
          idx   <= idx + 1'b1;
          if (last) begin
            c_out     <= c_nxt;
            over_flow <= msb_cin ^ c_nxt;
            idx       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
